y86_pipe_ctrl: RTL
==================

Name: y86_pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage Y86-64 core.
- Sequences the F/D/E/M/W pipeline registers, including execute_reg, by generating per-stage stall and bubble strobes.
- Detects load/use hazards and mispredicted conditional jumps.
- Runs a counter-based ret drain and an exception/halt state machine that freezes the machine once a non-AOK status reaches writeback.

Parameters:
- RET_DRAIN, 3, number of cycles fetch is held after a ret is seen in decode.
- RNONE, 4'hF, register ID meaning "no register"; never matches as a hazard.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_icode  in  4  icode currently in the decode stage.
- d_srcA  in  4  decode source register A.
- d_srcB  in  4  decode source register B.
- e_icode  in  4  icode in the execute stage.
- e_dstM  in  4  execute-stage memory destination register.
- e_cnd  in  1  execute-stage branch condition; 1 means taken.
- m_status  in  4  memory-stage status (one-hot: 0001 AOK, 0010 HLT, 0100 ADR, 1000 INS).
- w_status  in  4  writeback-stage status, same encoding.
- f_stall  out  1  hold the fetch PC register.
- d_stall  out  1  hold the decode register.
- d_bubble  out  1  load nop into the decode register.
- e_bubble  out  1  load nop into execute_reg.
- m_bubble  out  1  load nop into the memory register.
- w_stall  out  1  hold the writeback register.
- set_cc  out  1  condition-code write enable for execute.
- ctrl_state  out  2  00 RUN, 01 FAULT, 10 HALTED.

Behaviour:
- Reset (async, rst_n=0):
  - State = RUN, ret counter = 0.
  - All stall and bubble outputs = 0; set_cc = 1; ctrl_state = 00.
- Outputs are combinational from inputs plus registered state; there is zero-cycle latency from a hazard to its strobe.
- Load/use hazard: e_icode ∈ {5 mrmovq, B popq}, and e_dstM ≠ RNONE, and e_dstM equals d_srcA or d_srcB.
  - Response: f_stall=1, d_stall=1, e_bubble=1 for exactly that cycle.
- Mispredict: e_icode = 7 (jXX) and e_cnd = 0.
  - Response: d_bubble=1, e_bubble=1.
  - Any ret counter load in the same cycle is suppressed, because the ret is on the wrong path.
- Ret drain:
  - When d_icode = 9, there is no mispredict, and the counter is 0, the counter loads RET_DRAIN on the next edge.
  - While the counter ≠ 0 or d_icode = 9: f_stall=1 and d_bubble=1. The counter decrements each cycle down to 0.
  - If a load/use hazard and ret-in-decode coincide, d_stall wins: d_bubble=0, d_stall=1, and the counter does not load until the ret is actually released.
- d_stall and d_bubble are never both 1.
- Exception FSM:
  - RUN→FAULT when m_status ≠ 0001 or w_status ≠ 0001.
  - FAULT→HALTED when w_status ≠ 0001.
  - FAULT→RUN when both statuses are AOK again; this happens only if the faulting instruction was squashed.
  - HALTED is left only by reset.
- In FAULT:
  - m_bubble=1 and set_cc=0, so the faulting instruction's successors cannot update memory or CCs.
  - Hazard logic stays active.
- In HALTED:
  - f_stall=1, d_stall=1, w_stall=1; every bubble = 0; set_cc = 0.
  - The ret counter freezes.
- Reset asserted mid-drain or mid-FAULT returns to RUN with the counter cleared, asynchronously.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, three extra output ports are added, all 32-bit, all cleared on reset, all saturating at all-ones:
  - stall_cycles: counts cycles with f_stall=1 while in RUN or FAULT.
  - bubble_cycles: counts cycles with any bubble=1.
  - mispredicts: counts mispredict events.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: hold rst_n=0 with w_status=0010, then release with all statuses 0001 and all stage inputs idle → ctrl_state=00, all stalls/bubbles 0, set_cc=1.
- Load/use: e_icode=5, e_dstM=6, d_srcA=6 for one cycle → f_stall=d_stall=e_bubble=1 that cycle only. Repeat with e_dstM=F → no strobes.
- Mispredict: e_icode=7, e_cnd=0, d_icode=9 → d_bubble=e_bubble=1 and the ret counter stays 0. Next cycle, d_icode=1 → all strobes 0.
- Ret drain: d_icode=9 for one cycle, then 1 → f_stall=d_bubble=1 for 1+3 cycles, then 0.
- Halt: m_status=0010 for one cycle → FAULT with m_bubble=1, set_cc=0. Next cycle w_status=0010 → HALTED with f_stall=d_stall=w_stall=1. The machine stays HALTED for 10 cycles after both statuses return to 0001.
- Perf counters (PIPE_CTRL_PERF_EN defined): run the mispredict scenario twice and the ret drain once → mispredicts=2, stall_cycles=4, bubble_cycles=6.

Source files
------------

// File: rtl/y86_pipe_ctrl.sv
// y86_pipe_ctrl: pipeline control for the 5-stage Y86-64 core.
// Generates per-stage stall/bubble strobes from load/use hazards, jXX
// mispredicts and a counter-based ret drain, and runs a RUN/FAULT/HALTED
// exception FSM that freezes the pipe once a non-AOK status reaches W.
// Optional macro PIPE_CTRL_PERF_EN adds three saturating 32-bit
// performance counters (stall_cycles, bubble_cycles, mispredicts).
//
// Handshake note: this block has no valid/ready channels. Every output is
// a per-cycle level that is combinational from the current stage inputs
// and the registered state (ret counter, FSM state); stage registers are
// expected to honour the strobes on the next rising edge.
module y86_pipe_ctrl #(
  parameter int unsigned RET_DRAIN = 3,
  parameter logic [3:0]  RNONE     = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [3:0]  m_status,
  input  logic [3:0]  w_status,
  output logic        f_stall,
  output logic        d_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        m_bubble,
  output logic        w_stall,
  output logic        set_cc,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles,
  output logic [31:0] mispredicts,
`endif
  output logic [1:0]  ctrl_state
);

  localparam int unsigned CNT_W = $clog2(RET_DRAIN + 1);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'b0001;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FAULT  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mispredict;
  logic ret_in_d;
  logic ret_active;

  // Hazard detection; a ret on the wrong path of a mispredict is ignored.
  always_comb begin
    load_use   = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                 (e_dstM != RNONE) &&
                 ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    mispredict = (e_icode == I_JXX) && !e_cnd;
    ret_in_d   = (d_icode == I_RET) && !mispredict;
    ret_active = (cnt_q != '0) || ret_in_d;
  end

  // Stall/bubble strobes; HALTED freezes everything, d_stall beats d_bubble.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    set_cc   = 1'b0;
    if (state_q == ST_HALTED) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      w_stall = 1'b1;
    end else begin
      f_stall  = load_use || ret_active;
      d_stall  = load_use;
      d_bubble = mispredict || (ret_active && !load_use);
      e_bubble = load_use || mispredict;
      m_bubble = (state_q == ST_FAULT);
      set_cc   = (state_q == ST_RUN);
    end
  end

  // Ret drain counter next state: frozen when halted, loads only once the
  // ret actually leaves decode (not while a load/use stall holds it).
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_HALTED) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (ret_in_d && !load_use) begin
        cnt_d = CNT_W'(RET_DRAIN);
      end
    end
  end

  // Exception FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if ((m_status != S_AOK) || (w_status != S_AOK)) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (w_status != S_AOK)      state_d = ST_HALTED;
        else if (m_status == S_AOK) state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // State and ret counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, bubble_q, mp_q;
  logic        any_bubble;

  assign any_bubble = d_bubble || e_bubble || m_bubble;

  // Saturating performance counters; mispredicts are not counted when halted
  // because the hazard logic is frozen there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
      mp_q     <= '0;
    end else begin
      if (f_stall && (state_q != ST_HALTED) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (any_bubble && (bubble_q != '1))
        bubble_q <= bubble_q + 32'd1;
      if (mispredict && (state_q != ST_HALTED) && (mp_q != '1))
        mp_q <= mp_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
  assign mispredicts   = mp_q;
`endif

endmodule
